// File: rtl/dmem_arb.sv
// dmem_arb: arbitrates one data RAM port between the CPU MEM stage and a debug/loader port,
// with CPU priority, starvation forcing for debug, debug burst locking and read-return routing.
module dmem_arb #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [31:0]       ram_rdata
);
    typedef enum logic {OPEN, LOCKED} state_t;
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    state_t     state, state_nxt;
    logic [3:0] starve, starve_nxt;
    logic       force_dbg;
    always_comb begin
        force_dbg  = dbg_req && starve == SMAX;
        // grants are held low while reset is asserted, independent of the clock
        dbg_gnt    = rstb && dbg_req && (state == LOCKED || !cpu_req || force_dbg);
        cpu_gnt    = rstb && cpu_req && state == OPEN && !dbg_gnt;
        state_nxt  = state == LOCKED ? (dbg_lock ? LOCKED : OPEN)
                                     : (dbg_gnt && dbg_lock ? LOCKED : OPEN);
        starve_nxt = (!dbg_req || dbg_gnt) ? 4'd0 : (starve == SMAX ? starve : starve + 4'd1);
    end
    assign cpu_stall = cpu_req && !cpu_gnt;
    assign ram_addr  = dbg_gnt ? dbg_addr : cpu_addr;
    assign ram_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
    assign ram_be    = cpu_gnt ? cpu_be : (dbg_gnt ? 4'hF : 4'h0);
    assign ram_we    = (cpu_gnt && cpu_we) || (dbg_gnt && dbg_we);
    assign ram_re    = (cpu_gnt && !cpu_we) || (dbg_gnt && !dbg_we);
    assign cpu_rdata = ram_rdata;
    assign dbg_rdata = ram_rdata;
    // the rvalid flops double as the owner tag for the one-cycle read return
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= OPEN;
            starve     <= 4'd0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve     <= starve_nxt;
            cpu_rvalid <= cpu_gnt && !cpu_we;
            dbg_rvalid <= dbg_gnt && !dbg_we;
        end
    end
endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
Parameters:
REQ-001 The block SHALL provide parameter ADDR_W, default 32, meaning the byte-address width of both requester ports and the RAM port.
REQ-002 The block SHALL provide parameter STARVE_MAX, default 4, meaning the number of consecutive cycles a debug request may be denied before it is forced to win; legal range 1..15.

Ports:
REQ-003 The block SHALL have the following ports:
- clk  in  1  clock, all state updates on rising edge.
- rstb  in  1  reset; asynchronous, active-low.
- cpu_req  in  1  CPU (MEM stage) access request.
- cpu_we  in  1  CPU write (1) or read (0).
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_be  in  4  CPU byte enables.
- cpu_gnt  out  1  CPU access accepted this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes the pipeline.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  32  CPU read data.
- dbg_req  in  1  debug/loader access request.
- dbg_we  in  1  debug write/read.
- dbg_addr  in  ADDR_W  debug byte address.
- dbg_wdata  in  32  debug write data; byte enables fixed at 4'hF.
- dbg_lock  in  1  debug burst lock request.
- dbg_gnt  out  1  debug access accepted this cycle.
- dbg_rvalid  out  1  debug read data valid.
- dbg_rdata  out  32  debug read data.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_be  out  4  RAM byte enables.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_rdata  in  32  RAM read data, valid 1 cycle after ram_re.

Function
REQ-004 Grant SHALL be combinational in the request cycle; at most one of cpu_gnt and dbg_gnt SHALL be high in any cycle.
REQ-005 The FSM SHALL have states OPEN (normal arbitration) and LOCKED (debug owns RAM).
REQ-006 In OPEN, with no forcing condition, the CPU SHALL have priority and debug SHALL be granted only when cpu_req=0.
REQ-007 A 4-bit starve counter SHALL increment, saturating at STARVE_MAX, in each cycle with dbg_req=1 and dbg_gnt=0, and SHALL clear on dbg_gnt=1 or dbg_req=0.
REQ-008 When starve==STARVE_MAX and dbg_req=1, debug SHALL win over the CPU that cycle, and cpu_stall SHALL be 1 if cpu_req=1.
REQ-009 OPEN->LOCKED SHALL occur on a cycle with dbg_gnt=1 and dbg_lock=1.
REQ-010 In LOCKED, cpu_gnt SHALL be 0 and dbg_req SHALL be granted every cycle.
REQ-011 LOCKED->OPEN SHALL occur on the first cycle with dbg_lock=0; that cycle SHALL still be arbitrated as LOCKED.
REQ-012 The ram_* outputs SHALL carry the granted requester's fields; ram_we=gnt&we and ram_re=gnt&~we, with ram_be=cpu_be (CPU) or 4'hF (debug).
REQ-013 With no grant, ram_we, ram_re and ram_be SHALL be 0; ram_addr and ram_wdata are don't-care.
REQ-014 A registered owner tag SHALL route the read return: one cycle after a granted read, the owner's rvalid SHALL pulse for 1 cycle with rdata=ram_rdata, and the other port's rvalid SHALL stay 0.
REQ-015 Back-to-back reads from alternating owners SHALL each return correctly with 1-cycle latency.
REQ-016 rdata outputs SHALL be ram_rdata, qualified only by rvalid.
REQ-017 Writes SHALL produce no rvalid.

Reset
REQ-018 While rstb=0, the FSM SHALL be OPEN, starve=0, the owner tag cleared, and cpu_rvalid=dbg_rvalid=0, without waiting for clk.
REQ-019 While rstb=0, cpu_gnt, dbg_gnt, ram_we, ram_re and ram_be SHALL be forced to 0.
REQ-020 A read in flight when reset asserts SHALL produce no rvalid after reset releases.
REQ-021 The first grant after reset SHALL follow OPEN rules.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- CPU read 0x100 alone, ram_rdata=0xDEADBEEF -> cpu_gnt same cycle, cpu_rvalid next cycle with cpu_rdata=0xDEADBEEF, dbg_rvalid=0.
- cpu_req and dbg_req held high continuously, STARVE_MAX=4 -> CPU granted cycles 0-3, debug granted cycle 4 with cpu_stall=1, CPU regains the grant cycle 5.
- dbg write with dbg_lock=1 for 3 cycles, cpu_req=1 throughout -> 3 debug grants, cpu_stall=1 for 3 cycles, ram_be=4'hF; CPU granted the cycle after dbg_lock falls.
- CPU read then debug read on consecutive cycles -> cpu_rvalid then dbg_rvalid on consecutive cycles, each with its own data.
- CPU store cpu_be=4'b0011 -> ram_we=1, ram_be=4'b0011, no rvalid.
- rstb pulsed low between a granted read and its return -> no rvalid, FSM OPEN, starve=0.
